mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the counter width in bits (legal values 2..32).
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1, the terminal count, so the count range is 0..MAX (legal values 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter PRESCALE, default 1, the number of enabled cycles per count step (legal values 1..256).
REQ-004 The block SHALL have port clk  input  1  as its single clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port rstn  input  1  as an asynchronous, active-low reset.
REQ-006 The block SHALL have port data  input  WIDTH  as the load value.
REQ-007 The block SHALL have port load  input  1  as a synchronous load strobe.
REQ-008 The block SHALL have port en  input  1  as the count enable.
REQ-009 The block SHALL have port up  input  1  as the direction select: 1 = increment, 0 = decrement.
REQ-010 The block SHALL have port clr_ovf  input  1  as the synchronous clear for ovf.
REQ-011 The block SHALL have port count  output  WIDTH  as the registered count value.
REQ-012 The block SHALL have port wrap  output  1  as a registered one-cycle pulse flagging that a wrap occurred on the previous edge.
REQ-013 The block SHALL have port ovf  output  1  as a sticky, registered wrap flag.

Function
REQ-014 A load when load=1 SHALL set count to min(data, MAX) on the next edge, regardless of en and up.
REQ-015 A load SHALL reset the prescaler phase to 0 and SHALL NOT assert wrap.
REQ-016 With load=0 and en=1, the prescaler phase SHALL advance once per cycle; a step SHALL occur in the cycle in which the phase equals PRESCALE-1, and the phase SHALL then return to 0.
REQ-017 With PRESCALE=1, a step SHALL occur on every cycle in which en=1 and load=0.
REQ-018 With en=0, count and the prescaler phase SHALL hold their values.
REQ-019 An up step SHALL set count to count+1; when count=MAX, the step SHALL set count to 0 and is a wrap.
REQ-020 A down step SHALL set count to count-1; when count=0, the step SHALL set count to MAX and is a wrap.
REQ-021 The up input SHALL be sampled only in the step cycle; a direction change between steps SHALL take effect on the next step with no penalty cycle.
REQ-022 wrap SHALL be 1 for exactly the one cycle following each wrap step, and 0 otherwise.
REQ-023 ovf SHALL be set by a wrap step and cleared by clr_ovf=1; if both occur in the same cycle, set SHALL win.
REQ-024 Arithmetic SHALL be WIDTH bits with an explicit compare against MAX; intermediate overflow beyond WIDTH SHALL never be observable on count.

Reset
REQ-025 While rstn=0, count, the prescaler phase, wrap and ovf SHALL immediately be 0, independent of clk.
REQ-026 A reset asserted mid-prescale SHALL discard the phase; after rstn rises, the first step SHALL occur after PRESCALE enabled cycles.
REQ-027 Reset deassertion SHALL be synchronised by the integrator; the block SHALL assume no reset-release synchroniser.

Structure
REQ-028 A shared package mod_counter_pkg SHALL hold the direction constants (DIR_UP=1, DIR_DOWN=0) and a function clamping the load value to MAX.
REQ-029 The prescaler SHALL be a separate sub-module, count_prescaler (parameter PRESCALE; inputs clk, rstn, en, clr; output step), with clr driven by load.
REQ-030 count_prescaler SHALL reduce to combinational step = en when PRESCALE=1.

Verification (WIDTH=4, MAX=12, PRESCALE=1 unless stated)
REQ-031 Reset then up, en=1 for 14 cycles: count SHALL go 0..12, then 0; wrap SHALL pulse once after 12->0; ovf SHALL be 1.
REQ-032 Load data=15: count SHALL become 12 (clamped); a subsequent down count SHALL give 11,10,...,0,12, with wrap pulsing after 0->12.
REQ-033 Load data=5 with en=1, up=1 in the same cycle: the next value SHALL be 5 (load wins), followed by 6.
REQ-034 With PRESCALE=3 and en toggled 1,1,0,1: count SHALL increment only on the third enabled cycle; a load mid-phase SHALL restart the 3-cycle phase.
REQ-035 With ovf=1, assert clr_ovf in the same cycle as a wrap: ovf SHALL remain 1; assert clr_ovf alone: ovf SHALL become 0.
REQ-036 Drop rstn asynchronously mid-count (count=7, phase 1, PRESCALE=3): outputs SHALL go to 0 before the next clk edge, and the first step after release SHALL occur 3 enabled cycles later.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Direction encoding and load clamping live here so all users agree.
package mod_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Clamp a load value into the legal count range 0..max.
   function automatic logic [31:0] clamp_load(
      input logic [31:0] data,
      input logic [31:0] max
   );
      logic [31:0] res;
      res = (data > max) ? max : data;
      return res;
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler: emits one step per PRESCALE enabled cycles.
// A clear restarts the phase; PRESCALE=1 collapses to step = en.
module count_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic clr,
   output logic step
);

   if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $error("count_prescaler: PRESCALE out of range");
   end

   if (PRESCALE == 1) begin : g_direct

      logic unused_inputs;
      assign unused_inputs = ^{clk, rstn, clr};

      // No phase to track: every enabled cycle is a step.
      assign step = en;

   end else begin : g_phase

      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0] ONE  = PW'(1);

      logic [PW-1:0] phase_q;
      logic [PW-1:0] phase_d;
      logic          at_last;

      assign at_last = (phase_q == LAST);
      assign step    = en && at_last;

      // Advance phase on enabled cycles, wrapping after the step cycle.
      always_comb begin
         phase_d = phase_q;
         if (clr) begin
            phase_d = '0;
         end else if (en) begin
            phase_d = at_last ? '0 : phase_q + ONE;
         end
      end

      // Phase register; reset discards any partial prescale interval.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            phase_q <= '0;
         end else begin
            phase_q <= phase_d;
         end
      end

   end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-(MAX+1) up/down counter with load, prescaler and wrap flags.
// wrap is a one-cycle registered pulse; ovf is sticky until cleared.
module mod_updown_counter
   import mod_counter_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
   parameter int               PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] data,
   input  logic             load,
   input  logic             en,
   input  logic             up,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             ovf
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH out of range");
   end

   if (MAX == '0) begin : g_bad_max
      $error("mod_updown_counter: MAX must be nonzero");
   end

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             ovf_q;
   logic             ovf_d;

   logic             step;
   logic             do_load;
   logic             do_up;
   logic             do_dn;
   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] dec_val;

   count_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk (clk),
      .rstn(rstn),
      .en  (en),
      .clr (load),
      .step(step)
   );

   assign load_val = WIDTH'(clamp_load(32'(data), 32'(MAX)));
   assign at_max   = (count_q == MAX);
   assign at_zero  = (count_q == '0);
   assign inc_val  = at_max  ? '0  : count_q + ONE;
   assign dec_val  = at_zero ? MAX : count_q - ONE;

   assign do_load  = load;
   assign do_up    = !load && step && (up == DIR_UP);
   assign do_dn    = !load && step && (up == DIR_DOWN);

   // Next count: load beats stepping; direction sampled only on a step.
   always_comb begin
      count_d = count_q;
      unique case (1'b1)
         do_load: count_d = load_val;
         do_up:   count_d = inc_val;
         do_dn:   count_d = dec_val;
         default: count_d = count_q;
      endcase
   end

   // Wrap on the terminal step in either direction; set beats clear.
   always_comb begin
      wrap_d = (do_up && at_max) || (do_dn && at_zero);
      ovf_d  = wrap_d || (ovf_q && !clr_ovf);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter (WIDTH=4, MAX=12).
// Two instances share stimulus: PRESCALE=1 and PRESCALE=3.
module tb_mod_updown_counter;

   localparam int MAXV = 12;

   logic       clk;
   logic       rstn;
   logic [3:0] data;
   logic       load;
   logic       en;
   logic       up;
   logic       clr_ovf;
   logic [3:0] cnt1;
   logic       wrap1;
   logic       ovf1;
   logic [3:0] cnt3;
   logic       wrap3;
   logic       ovf3;

   mod_updown_counter #(
      .WIDTH(4), .MAX(4'd12), .PRESCALE(1)
   ) u_p1 (
      .clk(clk), .rstn(rstn), .data(data), .load(load), .en(en),
      .up(up), .clr_ovf(clr_ovf), .count(cnt1), .wrap(wrap1), .ovf(ovf1)
   );

   mod_updown_counter #(
      .WIDTH(4), .MAX(4'd12), .PRESCALE(3)
   ) u_p3 (
      .clk(clk), .rstn(rstn), .data(data), .load(load), .en(en),
      .up(up), .clr_ovf(clr_ovf), .count(cnt3), .wrap(wrap3), .ovf(ovf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int c0; int w0; int o0;
      int c1; int w1; int o1;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state per instance: count, phase, wrap, ovf.
   int ps[2] = '{1, 3};
   int mc[2];
   int mp[2];
   int mw[2];
   int mo[2];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mc[i] = 0; mp[i] = 0; mw[i] = 0; mo[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit l, input int d,
                             input bit e, input bit u, input bit c);
      bit w;
      w = 1'b0;
      if (l) begin
         mc[i] = (d > MAXV) ? MAXV : d;
         mp[i] = 0;
      end else if (e) begin
         if (mp[i] == ps[i] - 1) begin
            mp[i] = 0;
            if (u) begin
               if (mc[i] == MAXV) begin mc[i] = 0; w = 1'b1; end
               else mc[i] = mc[i] + 1;
            end else begin
               if (mc[i] == 0) begin mc[i] = MAXV; w = 1'b1; end
               else mc[i] = mc[i] - 1;
            end
         end else begin
            mp[i] = mp[i] + 1;
         end
      end
      mw[i] = w ? 1 : 0;
      if (w) mo[i] = 1;
      else if (c) mo[i] = 0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.c0 = mc[0]; e.w0 = mw[0]; e.o0 = mo[0];
      e.c1 = mc[1]; e.w1 = mw[1]; e.o1 = mo[1];
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit l, input int d, input bit e,
                        input bit u, input bit c);
      @(negedge clk);
      rstn = 1'b1; load = l; data = 4'(d); en = e; up = u; clr_ovf = c;
      for (int i = 0; i < 2; i++) model_step(i, l, d, e, u, c);
      push_exp();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_count_p1"}, int'(cnt1), 0);
      chk({tag, "_wrap_p1"}, int'(wrap1), 0);
      chk({tag, "_ovf_p1"}, int'(ovf1), 0);
      chk({tag, "_count_p3"}, int'(cnt3), 0);
      chk({tag, "_wrap_p3"}, int'(wrap3), 0);
      chk({tag, "_ovf_p3"}, int'(ovf3), 0);
   endtask

   // Drop reset between edges and confirm outputs clear before any edge.
   task automatic async_reset();
      @(negedge clk);
      load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
      #2 rstn = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      push_exp();
   endtask

   // Monitor: every edge the DUT presents a new registered state.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count_p1", int'(cnt1), e.c0);
            chk("wrap_p1", int'(wrap1), e.w0);
            chk("ovf_p1", int'(ovf1), e.o0);
            chk("count_p3", int'(cnt3), e.c1);
            chk("wrap_p3", int'(wrap3), e.w1);
            chk("ovf_p3", int'(ovf3), e.o1);
         end
      end
   end

   initial begin
      rstn = 1'b1; load = 1'b0; data = '0; en = 1'b0;
      up = 1'b1; clr_ovf = 1'b0;
      #1 rstn = 1'b0;
      #2 check_zero("reset");
      model_reset();

      // Count up through the terminal value and wrap.
      for (int k = 0; k < 14; k++) drive(0, 0, 1, 1, 0);
      // Clamped load, then count down through zero.
      drive(1, 15, 0, 0, 0);
      for (int k = 0; k < 14; k++) drive(0, 0, 1, 0, 0);
      // Load wins over a simultaneous count request.
      drive(1, 5, 1, 1, 0);
      drive(0, 0, 1, 1, 0);
      // Gapped enable on the prescaled instance, then a mid-phase load.
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 1, 0); drive(0, 0, 1, 1, 0);
         drive(0, 0, 0, 1, 0); drive(0, 0, 1, 1, 0);
      end
      drive(0, 0, 1, 1, 0);
      drive(1, 3, 1, 1, 0);
      for (int k = 0; k < 4; k++) drive(0, 0, 1, 1, 0);
      // Wrap coincident with clr_ovf keeps ovf; clr_ovf alone clears.
      drive(1, 12, 0, 1, 0);
      drive(0, 0, 1, 1, 1);
      drive(0, 0, 0, 1, 1);
      // Reset mid-prescale with count 7 and phase 1.
      drive(1, 7, 0, 1, 0);
      drive(0, 0, 1, 1, 0);
      async_reset();
      for (int k = 0; k < 5; k++) drive(0, 0, 1, 1, 0);

      // Randomised traffic.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(99) == 0) begin
            async_reset();
         end else begin
            drive($urandom_range(9) == 0,
                  int'($urandom_range(15)),
                  $urandom_range(3) != 0,
                  $urandom_range(1) == 1,
                  $urandom_range(9) == 0);
         end
      end

      drive(0, 0, 0, 1, 0);
      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
